mpsoc_wb_pic: RTL and testbench

MPSOC_WB_PIC -- requirements
Module: mpsoc_wb_pic

---
 rtl/mpsoc_wb_pic.sv | 114 +++++++++++
 tb/tb_mpsoc_wb_pic.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mpsoc_wb_pic.sv
// Wishbone interrupt controller with PEND (W1C), MASK, MODE (1=edge, 0=level) and RAW registers, plus a registered irq_o.
// Source-to-irq_o latency is 3 cycles, or 4 when the PIC_SYNC_EN macro adds a 2-flop synchronizer; every request is acked on the next cycle.
module mpsoc_wb_pic #(
    parameter int          NUM_IRQ  = 32,
    parameter logic [31:0] MASK_RST = 32'h0000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [3:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic [31:0]        irq_o
);
    localparam logic [31:0] VALID = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'h1 << NUM_IRQ) - 32'h1);
    localparam logic [1:0] ADR_PEND = 2'd0;
    localparam logic [1:0] ADR_MASK = 2'd1;
    localparam logic [1:0] ADR_MODE = 2'd2;
    localparam logic [1:0] ADR_RAW  = 2'd3;

    logic [31:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic [31:0] cond_q, prev_q, irq_q, dat_q, dat_d;
    logic        ack_q, ack_d;
    logic [31:0] src_ext, bmask, clr, edge_set, rdata;
    logic        req, wr;
    logic [1:0]  reg_sel;
    logic [1:0]  unused_adr;

    always_comb begin
        src_ext = '0;
        src_ext[NUM_IRQ-1:0] = irq_src_i;
    end

    assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr         = req & wb_we_i;
    assign reg_sel    = wb_adr_i[3:2];
    assign unused_adr = wb_adr_i[1:0];
    assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // Source conditioning: cond_q is the level seen by edge detection and RAW.
`ifdef PIC_SYNC_EN
    logic [31:0] meta_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            meta_q <= '0;
            cond_q <= '0;
        end else begin
            meta_q <= src_ext & VALID;
            cond_q <= meta_q;
        end
    end
`else
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cond_q <= '0;
        end else begin
            cond_q <= src_ext & VALID;
        end
    end
`endif

    always_comb begin
        edge_set = cond_q & ~prev_q & mode_q;
        clr      = '0;
        mask_d   = mask_q;
        mode_d   = mode_q;
        if (wr && reg_sel == ADR_PEND) clr = wb_dat_i & bmask;
        if (wr && reg_sel == ADR_MASK) mask_d = ((mask_q & ~bmask) | (wb_dat_i & bmask)) & VALID;
        if (wr && reg_sel == ADR_MODE) mode_d = ((mode_q & ~bmask) | (wb_dat_i & bmask)) & VALID;
        // Edge bits: a new edge beats a simultaneous W1C. Level bits track the source.
        pend_d = ((((pend_q & ~clr) | edge_set) & mode_q) | (cond_q & ~mode_q)) & VALID;
        case (reg_sel)
            ADR_PEND: rdata = pend_q;
            ADR_MASK: rdata = mask_q;
            ADR_MODE: rdata = mode_q;
            ADR_RAW:  rdata = cond_q;
            default:  rdata = '0;
        endcase
        ack_d = req;
        dat_d = req ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend_q <= '0;
            mask_q <= MASK_RST & VALID;
            mode_q <= '0;
            prev_q <= '0;
            irq_q  <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            prev_q <= cond_q;
            irq_q  <= pend_q & mask_q;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_err_o = 1'b0;
    assign irq_o    = irq_q;
endmodule

// File: tb/tb_mpsoc_wb_pic.sv
// Directed bench for mpsoc_wb_pic (NUM_IRQ=16, MASK_RST=0x100).
module tb_mpsoc_wb_pic;
`ifdef PIC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam logic [31:0] MRST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0] dat_o;
    logic        ack_o, err_o;
    logic [15:0] src = '0;
    logic [31:0] irq;
    logic [31:0] rd;
    int          n_chk = 0;
    int          n_fail = 0;

    mpsoc_wb_pic #(.NUM_IRQ(16), .MASK_RST(MRST)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(dat_o), .wb_ack_o(ack_o), .wb_err_o(err_o),
        .irq_src_i(src), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one transfer from a post-edge point and returns just after the ack edge.
    task automatic xfer(input logic [3:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        logic got;
        got = 1'b0;
        adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 4 && !got; k++) begin
            tick();
            got = ack_o;
        end
        chk("ack", {31'b0, ack_o}, 32'h1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_irq", irq, 32'h0);
        chk("rst_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        rst = 1'b0;
        tick();
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("rd_pend0", rd, 32'h0);
        xfer(4'h4, 1'b0, 32'h0, 4'hF, rd); chk("rd_mask0", rd, MRST);
        xfer(4'h8, 1'b0, 32'h0, 4'hF, rd); chk("rd_mode0", rd, 32'h0);
        xfer(4'hC, 1'b0, 32'h0, 4'hF, rd); chk("rd_raw0", rd, 32'h0);
        chk("irq0", irq, 32'h0);
        chk("err", {31'b0, err_o}, 32'h0);

        // Edge mode pulse on source 2
        xfer(4'h8, 1'b1, 32'h4, 4'hF, rd);
        xfer(4'h4, 1'b1, 32'h4, 4'hF, rd);
        xfer(4'h8, 1'b0, 32'h0, 4'hF, rd); chk("rd_mode4", rd, 32'h4);
        src[2] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) src[2] = 1'b0;
            if (k == LAT - 1) chk("edge_irq_early", irq, 32'h0);
        end
        chk("edge_irq", irq, 32'h4);
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("edge_pend", rd, 32'h4);
        xfer(4'h0, 1'b1, 32'h4, 4'hF, rd);
        chk("w1c_irq_ack", irq, 32'h4);
        tick();
        chk("w1c_irq_clr", irq, 32'h0);

        // Level mode: W1C ignored, follows source
        xfer(4'h8, 1'b1, 32'h0, 4'hF, rd);
        src[2] = 1'b1;
        repeat (LAT) tick();
        chk("lvl_irq", irq, 32'h4);
        xfer(4'h0, 1'b1, 32'h4, 4'hF, rd);
        repeat (2) tick();
        chk("lvl_irq_w1c", irq, 32'h4);
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("lvl_pend", rd, 32'h4);
        xfer(4'hC, 1'b0, 32'h0, 4'hF, rd); chk("lvl_raw", rd, 32'h4);
        src[2] = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) chk("lvl_drop_early", irq, 32'h4);
        end
        chk("lvl_drop", irq, 32'h0);

        // Edge and W1C on the same edge: set wins
        xfer(4'h8, 1'b1, 32'h4, 4'hF, rd);
        repeat (2) tick();
        src[2] = 1'b1;
        for (int k = 1; k <= LAT - 2; k++) tick();
        adr = 4'h0; we = 1'b1; wdat = 32'h4; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        tick();
        chk("race_ack", {31'b0, ack_o}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        src[2] = 1'b0;
        tick();
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("race_pend", rd, 32'h4);
        xfer(4'h0, 1'b1, 32'h4, 4'hF, rd);
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("race_pend_clr", rd, 32'h0);

        // Byte enables and held strobe
        tick();
        adr = 4'h4; we = 1'b1; wdat = 32'hFFFF_FFFF; sel = 4'b0001; cyc = 1'b1; stb = 1'b1;
        tick(); chk("held_ack1", {31'b0, ack_o}, 32'h1);
        tick(); chk("held_ack2", {31'b0, ack_o}, 32'h0);
        tick(); chk("held_ack3", {31'b0, ack_o}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        xfer(4'h4, 1'b0, 32'h0, 4'hF, rd); chk("mask_sel", rd, 32'h0000_00FF);
        xfer(4'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(4'h4, 1'b0, 32'h0, 4'hF, rd); chk("mask_width", rd, 32'h0000_FFFF);
        xfer(4'hC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(4'hC, 1'b0, 32'h0, 4'hF, rd); chk("raw_ro", rd, 32'h0);

        // Reset in the middle of a transfer
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        repeat (LAT) tick();
        chk("pre_rst_irq", irq, 32'h4);
        adr = 4'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_irq", irq, 32'h0);
        chk("midrst_ack", {31'b0, ack_o}, 32'h0);
        tick();
        chk("midrst_ack2", {31'b0, ack_o}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        xfer(4'h0, 1'b0, 32'h0, 4'hF, rd); chk("post_rst_pend", rd, 32'h0);
        xfer(4'h4, 1'b0, 32'h0, 4'hF, rd); chk("post_rst_mask", rd, MRST);
        xfer(4'h8, 1'b0, 32'h0, 4'hF, rd); chk("post_rst_mode", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
